// File: rtl/copmem_arbiter_pkg.sv
// Shared types and constants for the copper program memory access controller.
package copmem_arbiter_pkg;

  localparam int unsigned COPMEM_AWIDTH = 10;
  localparam int unsigned BANK_SEL_BIT  = 0;

  typedef struct packed {
    logic is_cop;
    logic is_host;
    logic lsb;
  } copmem_tag_t;

endpackage

// File: rtl/copmem_rd_pipe.sv
// Two-stage read tag pipeline; steers BRAM read data to the copper or host
// port and overlays forwarded write data onto the matching bank half.
module copmem_rd_pipe
  import copmem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n_i,
  input  copmem_tag_t issue_tag,
  input  logic        fwd_even,
  input  logic        fwd_odd,
  input  logic [15:0] fwd_data,
  input  logic [15:0] even_rd_data_i,
  input  logic [15:0] odd_rd_data_i,
  output logic        cop_valid_o,
  output logic [31:0] cop_data_o,
  output logic        host_rd_valid_o,
  output logic [15:0] host_rd_data_o
);

  copmem_tag_t tag_s1, tag_s2;
  logic [1:0]  fwd_even_q, fwd_odd_q;
  logic [15:0] fwd_data_s1, fwd_data_s2;
  logic [15:0] even_word, odd_word;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tag_s1      <= '0;
      tag_s2      <= '0;
      fwd_even_q  <= '0;
      fwd_odd_q   <= '0;
      fwd_data_s1 <= '0;
      fwd_data_s2 <= '0;
    end else begin
      tag_s1      <= issue_tag;
      tag_s2      <= tag_s1;
      fwd_even_q  <= {fwd_even_q[0], fwd_even};
      fwd_odd_q   <= {fwd_odd_q[0], fwd_odd};
      fwd_data_s1 <= fwd_data;
      fwd_data_s2 <= fwd_data_s1;
    end
  end

  always_comb begin
    even_word       = fwd_even_q[1] ? fwd_data_s2 : even_rd_data_i;
    odd_word        = fwd_odd_q[1]  ? fwd_data_s2 : odd_rd_data_i;
    cop_valid_o     = tag_s2.is_cop;
    host_rd_valid_o = tag_s2.is_host;
    cop_data_o      = tag_s2.is_cop ? {even_word, odd_word} : '0;
    host_rd_data_o  = '0;
    if (tag_s2.is_host) begin
      host_rd_data_o = tag_s2.lsb ? odd_word : even_word;
    end
  end

endmodule

// File: rtl/copmem_arbiter.sv
// Copper program memory arbiter: copper fetch and host read/write onto the
// even/odd BRAM banks. Define COPMEM_WR_FWD_EN to forward instead of stalling.
module copmem_arbiter
  import copmem_arbiter_pkg::*;
#(
  parameter int unsigned AWIDTH        = COPMEM_AWIDTH,
  parameter int unsigned HOST_WAIT_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              cop_req_i,
  input  logic [AWIDTH-1:0] cop_addr_i,
  output logic              cop_ack_o,
  output logic              cop_valid_o,
  output logic [31:0]       cop_data_o,
  input  logic              host_req_i,
  input  logic              host_wr_i,
  input  logic [AWIDTH:0]   host_addr_i,
  input  logic [15:0]       host_data_i,
  output logic              host_ack_o,
  output logic              host_rd_valid_o,
  output logic [15:0]       host_rd_data_o,
  output logic [AWIDTH-1:0] even_rd_addr_o,
  output logic [AWIDTH-1:0] odd_rd_addr_o,
  input  logic [15:0]       even_rd_data_i,
  input  logic [15:0]       odd_rd_data_i,
  output logic              even_wr_en_o,
  output logic              odd_wr_en_o,
  output logic [AWIDTH-1:0] mem_wr_addr_o,
  output logic [15:0]       mem_wr_data_o
);

  localparam int unsigned WAIT_W = (HOST_WAIT_MAX < 1) ? 1 : $clog2(HOST_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_WAIT_MAX);

  logic [WAIT_W-1:0] host_wait;
  logic [AWIDTH-1:0] host_lw_addr;
  logic              host_lsb, wr_active, cop_hit, host_hit, cop_block, host_block;
  logic              host_rd_pend, host_rd_gnt, cop_rd_gnt, host_wr_gnt;
  logic              fwd_even, fwd_odd;
  copmem_tag_t       issue_tag;

  // Acks are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    host_lw_addr = host_addr_i[AWIDTH:1];
    host_lsb     = host_addr_i[BANK_SEL_BIT];
    wr_active    = even_wr_en_o | odd_wr_en_o;
    cop_hit      = wr_active && (cop_addr_i == mem_wr_addr_o);
    host_hit     = wr_active && (host_lw_addr == mem_wr_addr_o);
`ifdef COPMEM_WR_FWD_EN
    cop_block    = 1'b0;
    host_block   = 1'b0;
`else
    cop_block    = cop_hit;
    host_block   = host_hit;
`endif
    host_rd_pend = host_req_i & ~host_wr_i;
    host_rd_gnt  = reset_n_i & host_rd_pend & ~host_block &
                   ((host_wait == WAIT_MAX) | ~cop_req_i | cop_block);
    cop_rd_gnt   = reset_n_i & cop_req_i & ~cop_block & ~host_rd_gnt;
    host_wr_gnt  = reset_n_i & host_req_i & host_wr_i;
    cop_ack_o    = cop_rd_gnt;
    host_ack_o   = host_rd_gnt | host_wr_gnt;

    issue_tag.is_cop  = cop_rd_gnt;
    issue_tag.is_host = host_rd_gnt;
    issue_tag.lsb     = host_rd_gnt & host_lsb;

    fwd_even = 1'b0;
    fwd_odd  = 1'b0;
`ifdef COPMEM_WR_FWD_EN
    if ((cop_rd_gnt && cop_hit) || (host_rd_gnt && host_hit)) begin
      fwd_even = even_wr_en_o;
      fwd_odd  = odd_wr_en_o;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      even_wr_en_o   <= 1'b0;
      odd_wr_en_o    <= 1'b0;
      mem_wr_addr_o  <= '0;
      mem_wr_data_o  <= '0;
      even_rd_addr_o <= '0;
      odd_rd_addr_o  <= '0;
      host_wait      <= '0;
    end else begin
      even_wr_en_o <= host_wr_gnt & ~host_lsb;
      odd_wr_en_o  <= host_wr_gnt & host_lsb;
      if (host_wr_gnt) begin
        mem_wr_addr_o <= host_lw_addr;
        mem_wr_data_o <= host_data_i;
      end
      if (cop_rd_gnt) begin
        even_rd_addr_o <= cop_addr_i;
        odd_rd_addr_o  <= cop_addr_i;
      end else if (host_rd_gnt) begin
        even_rd_addr_o <= host_lw_addr;
        odd_rd_addr_o  <= host_lw_addr;
      end
      if (host_rd_gnt) begin
        host_wait <= '0;
      end else if (host_rd_pend && (host_wait != WAIT_MAX)) begin
        host_wait <= host_wait + 1'b1;
      end
    end
  end

  copmem_rd_pipe u_rd_pipe (
    .clk             (clk),
    .reset_n_i       (reset_n_i),
    .issue_tag       (issue_tag),
    .fwd_even        (fwd_even),
    .fwd_odd         (fwd_odd),
    .fwd_data        (mem_wr_data_o),
    .even_rd_data_i  (even_rd_data_i),
    .odd_rd_data_i   (odd_rd_data_i),
    .cop_valid_o     (cop_valid_o),
    .cop_data_o      (cop_data_o),
    .host_rd_valid_o (host_rd_valid_o),
    .host_rd_data_o  (host_rd_data_o)
  );

endmodule

// File: tb/tb_copmem_arbiter.sv
// Scoreboard bench for copmem_arbiter with a read-first BRAM model per bank.
module tb_copmem_arbiter;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          cop_req_i;
  logic [AW-1:0] cop_addr_i;
  logic          cop_ack_o, cop_valid_o;
  logic [31:0]   cop_data_o;
  logic          host_req_i, host_wr_i;
  logic [AW:0]   host_addr_i;
  logic [15:0]   host_data_i;
  logic          host_ack_o, host_rd_valid_o;
  logic [15:0]   host_rd_data_o;
  logic [AW-1:0] even_rd_addr_o, odd_rd_addr_o;
  logic [15:0]   even_rd_data_i, odd_rd_data_i;
  logic          even_wr_en_o, odd_wr_en_o;
  logic [AW-1:0] mem_wr_addr_o;
  logic [15:0]   mem_wr_data_o;

  logic [15:0] even_mem [1024];
  logic [15:0] odd_mem  [1024];
  logic [31:0] exp_cop  [$];
  logic [15:0] exp_host [$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  copmem_arbiter #(.AWIDTH(AW), .HOST_WAIT_MAX(4)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .cop_req_i(cop_req_i), .cop_addr_i(cop_addr_i), .cop_ack_o(cop_ack_o),
    .cop_valid_o(cop_valid_o), .cop_data_o(cop_data_o),
    .host_req_i(host_req_i), .host_wr_i(host_wr_i), .host_addr_i(host_addr_i),
    .host_data_i(host_data_i), .host_ack_o(host_ack_o),
    .host_rd_valid_o(host_rd_valid_o), .host_rd_data_o(host_rd_data_o),
    .even_rd_addr_o(even_rd_addr_o), .odd_rd_addr_o(odd_rd_addr_o),
    .even_rd_data_i(even_rd_data_i), .odd_rd_data_i(odd_rd_data_i),
    .even_wr_en_o(even_wr_en_o), .odd_wr_en_o(odd_wr_en_o),
    .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o)
  );

  // BRAM model: even[i] = A000|i, odd[i] = 5000|i, registered read, old data on collision
  initial begin
    for (int i = 0; i < 1024; i++) begin
      even_mem[i] = 16'hA000 | 16'(i);
      odd_mem[i]  = 16'h5000 | 16'(i);
    end
    even_rd_data_i = '0;
    odd_rd_data_i  = '0;
    forever begin
      @(posedge clk);
      even_rd_data_i <= even_mem[even_rd_addr_o];
      odd_rd_data_i  <= odd_mem[odd_rd_addr_o];
      if (even_wr_en_o) even_mem[mem_wr_addr_o] <= mem_wr_data_o;
      if (odd_wr_en_o)  odd_mem[mem_wr_addr_o]  <= mem_wr_data_o;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid pulse must match the oldest expected response
  always @(negedge clk) begin
    logic [31:0] ec;
    logic [15:0] eh;
    if (cop_valid_o === 1'b1) begin
      if (exp_cop.size() == 0) begin
        checks++; failures++;
        $display("FAIL cop_unexpected_valid actual=%0h required=no_pulse", cop_data_o);
      end else begin
        ec = exp_cop.pop_front();
        check("cop_data", {96'd0, cop_data_o}, {96'd0, ec});
      end
    end
    if (host_rd_valid_o === 1'b1) begin
      if (exp_host.size() == 0) begin
        checks++; failures++;
        $display("FAIL host_unexpected_valid actual=%0h required=no_pulse", host_rd_data_o);
      end else begin
        eh = exp_host.pop_front();
        check("host_rd_data", {112'd0, host_rd_data_o}, {112'd0, eh});
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return {28'd0, cop_ack_o, cop_valid_o, cop_data_o, host_ack_o, host_rd_valid_o,
            host_rd_data_o, even_rd_addr_o, odd_rd_addr_o, even_wr_en_o, odd_wr_en_o,
            mem_wr_addr_o, mem_wr_data_o};
  endfunction

  initial begin
    logic [AW-1:0] cur;
    logic          exp_ack;
    reset_n_i = 1'b0; cop_req_i = 1'b0; cop_addr_i = '0;
    host_req_i = 1'b0; host_wr_i = 1'b0; host_addr_i = '0; host_data_i = '0;
    tick(); tick();
    cop_req_i = 1'b1; host_req_i = 1'b1; host_wr_i = 1'b1;
    #1 check("reset_outputs_zero", all_outs(), '0);

    // Basic copper fetch out of reset
    tick();
    reset_n_i = 1'b1; host_req_i = 1'b0; host_wr_i = 1'b0;
    cop_req_i = 1'b1; cop_addr_i = 10'h005;
    #1 check("cop_ack_c0", 128'(cop_ack_o), 128'd1);
    exp_cop.push_back({16'hA005, 16'h5005});
    tick(); cop_req_i = 1'b0;
    #1 check("rd_addr_c1", {even_rd_addr_o, odd_rd_addr_o}, {10'h005, 10'h005});
    check("cop_valid_c1", 128'(cop_valid_o), 128'd0);
    tick();
    #1 check("cop_valid_c2", 128'(cop_valid_o), 128'd1);

    // Host write then read-back
    tick();
    host_req_i = 1'b1; host_wr_i = 1'b1; host_addr_i = 11'h00B; host_data_i = 16'hBEEF;
    #1 check("host_wr_ack", 128'(host_ack_o), 128'd1);
    tick(); host_req_i = 1'b0;
    #1 check("wr_port", {even_wr_en_o, odd_wr_en_o, mem_wr_addr_o, mem_wr_data_o},
             {1'b0, 1'b1, 10'h005, 16'hBEEF});
    tick();
    host_req_i = 1'b1; host_wr_i = 1'b0; host_addr_i = 11'h00B;
    #1 check("host_rd_ack", 128'(host_ack_o), 128'd1);
    exp_host.push_back(16'hBEEF);
    tick(); host_req_i = 1'b0;
    tick(); tick(); tick();

    // Copper stream with a pending host read: host forced through on 5th pending cycle
    cur = 10'h010;
    host_req_i = 1'b1; host_wr_i = 1'b0; host_addr_i = 11'h002;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      if (k > 4) host_req_i = 1'b0;
      cop_req_i = 1'b1; cop_addr_i = cur;
      exp_ack = (k != 4);
      #1 check($sformatf("starve_cop_ack_k%0d", k), 128'(cop_ack_o), 128'(exp_ack));
      check($sformatf("starve_host_ack_k%0d", k), 128'(host_ack_o), 128'(k == 4));
      if (exp_ack) begin
        exp_cop.push_back({16'hA000 | 16'(cur), 16'h5000 | 16'(cur)});
        cur = cur + 1'b1;
      end else begin
        exp_host.push_back(16'hA001);
      end
    end
    tick(); cop_req_i = 1'b0;
    tick(); tick(); tick();

    // Read-during-write hazard on long word 8, even bank
    host_req_i = 1'b1; host_wr_i = 1'b1; host_addr_i = 11'h010; host_data_i = 16'h1234;
    #1 check("hz_wr_ack", 128'(host_ack_o), 128'd1);
    tick(); host_req_i = 1'b0; cop_req_i = 1'b1; cop_addr_i = 10'h008;
`ifdef COPMEM_WR_FWD_EN
    #1 check("hz_cop_ack_n1", 128'(cop_ack_o), 128'd1);
    exp_cop.push_back({16'h1234, 16'h5008});
    tick(); cop_req_i = 1'b0;
`else
    #1 check("hz_cop_ack_n1", 128'(cop_ack_o), 128'd0);
    tick();
    #1 check("hz_cop_ack_n2", 128'(cop_ack_o), 128'd1);
    exp_cop.push_back({16'h1234, 16'h5008});
    tick(); cop_req_i = 1'b0;
`endif
    tick(); tick(); tick();

    // Reset right after a copper grant drops the in-flight read
    cop_req_i = 1'b1; cop_addr_i = 10'h033;
    #1 check("rst_cop_ack", 128'(cop_ack_o), 128'd1);
    tick();
    reset_n_i = 1'b0; host_req_i = 1'b1; host_wr_i = 1'b1;
    #1 check("rst_mid_outputs_zero", all_outs(), '0);
    tick(); tick();
    #1 check("rst_hold_outputs_zero", all_outs(), '0);
    tick();
    reset_n_i = 1'b1; cop_req_i = 1'b0; host_req_i = 1'b0; host_wr_i = 1'b0;
    tick(); tick(); tick();

    // Wrap-around back-to-back fetches
    cop_req_i = 1'b1; cop_addr_i = 10'h3FF;
    #1 check("wrap_ack0", 128'(cop_ack_o), 128'd1);
    exp_cop.push_back({16'hA3FF, 16'h53FF});
    tick(); cop_addr_i = 10'h000;
    #1 check("wrap_ack1", 128'(cop_ack_o), 128'd1);
    exp_cop.push_back({16'hA000, 16'h5000});
    tick(); cop_req_i = 1'b0;
    #1 check("wrap_valid0", 128'(cop_valid_o), 128'd1);
    tick();
    #1 check("wrap_valid1", 128'(cop_valid_o), 128'd1);
    tick();

    // Host write and copper read acknowledged together
    cop_req_i = 1'b1; cop_addr_i = 10'h020;
    host_req_i = 1'b1; host_wr_i = 1'b1; host_addr_i = 11'h051; host_data_i = 16'hCAFE;
    #1 check("dual_acks", {cop_ack_o, host_ack_o}, 2'b11);
    exp_cop.push_back({16'hA020, 16'h5020});
    tick(); cop_req_i = 1'b0; host_req_i = 1'b0; host_wr_i = 1'b0;
    #1 check("dual_wr_port", {even_wr_en_o, odd_wr_en_o, mem_wr_addr_o, mem_wr_data_o},
             {1'b0, 1'b1, 10'h028, 16'hCAFE});
    for (int i = 0; i < 6; i++) tick();

    check("cop_queue_drained", 128'(exp_cop.size()), 128'd0);
    check("host_queue_drained", 128'(exp_host.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
